// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  // Responder FSM states; the encoding is visible on the stateout debug port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Access size encodings on req_size
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Latency counter width; covers LATENCY up to 15
  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath (master) and the memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_lane_unit.sv
// Little-endian byte-lane steering: store merge, load extract, alignment check.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o  // also set for the illegal size encoding
);

  logic [4:0] shift;

  // Lane select by size and low address bits; unaddressed bytes keep old_word_i
  always_comb begin
    merged_o   = old_word_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    shift      = '0;
    case (size_i)
      SIZE_BYTE: begin
        shift    = {addr_lo_i, 3'b000};
        merged_o = (old_word_i & ~(32'h0000_00ff << shift)) | ({24'h0, wdata_i[7:0]} << shift);
        rdata_o  = {24'h0, 8'(old_word_i >> shift)};
      end
      SIZE_HALF: begin
        shift      = {addr_lo_i[1], 4'b0000};
        misalign_o = addr_lo_i[0];
        merged_o   = (old_word_i & ~(32'h0000_ffff << shift)) | ({16'h0, wdata_i[15:0]} << shift);
        rdata_o    = {16'h0, 16'(old_word_i >> shift)};
      end
      SIZE_WORD: begin
        misalign_o = |addr_lo_i;
        merged_o   = wdata_i;
        rdata_o    = old_word_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding load/store, one-cycle response pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic [1:0]     stateout
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_state_e        state_q, state_d;
  logic [LAT_W-1:0]  count_q, count_d;
  logic              req_write_q, req_write_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic              mem_we;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              idle;
  logic              sel_write;
  logic [1:0]        sel_size;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              in_range;
  logic [IdxW-1:0]   word_idx;
  logic [31:0]       old_word;
  logic [31:0]       lane_merged;
  logic [31:0]       lane_rdata;
  logic              lane_misalign;
  logic              acc_error;
  logic [31:0]       rsp_data;

  assign idle = (state_q == IDLE);

  // In IDLE the live bus request is decoded so LATENCY=1 can respond on the next cycle;
  // otherwise the captured request drives the lane unit and array access
  always_comb begin
    sel_write = req_write_q;
    sel_size  = req_size_q;
    sel_addr  = req_addr_q;
    sel_wdata = req_wdata_q;
    if (idle) begin
      sel_write = bus.req_write;
      sel_size  = bus.req_size;
      sel_addr  = bus.req_addr;
      sel_wdata = bus.req_wdata;
    end
  end

  assign in_range  = ({2'b00, sel_addr[31:2]} < DEPTH_WORDS);
  assign word_idx  = sel_addr[IdxW+1:2];
  assign old_word  = in_range ? mem_q[word_idx] : '0;
  assign acc_error = lane_misalign | ~in_range;
  assign rsp_data  = (acc_error || sel_write) ? '0 : lane_rdata;

  mem_lane_unit u_lane (
    .size_i     (sel_size),
    .addr_lo_i  (sel_addr[1:0]),
    .old_word_i (old_word),
    .wdata_i    (sel_wdata),
    .merged_o   (lane_merged),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

  // Next-state: accept in IDLE, count down in WAIT, pulse and commit in RESP
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    req_write_d = req_write_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_write_d = bus.req_write;
          req_size_d  = bus.req_size;
          req_addr_d  = bus.req_addr;
          req_wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d     = RESP;
            count_d     = '0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rsp_data;
            rsp_error_d = acc_error;
          end else begin
            state_d = WAIT;
            count_d = LAT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_d = count_q - LAT_W'(1);
        // Count reaching zero means the next cycle is T+LATENCY
        if (count_q == LAT_W'(1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rsp_data;
          rsp_error_d = acc_error;
        end
      end
      RESP: begin
        state_d = IDLE;
        mem_we  = req_write_q & ~acc_error;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      req_write_q <= 1'b0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      req_write_q <= req_write_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Storage array; not cleared by reset, and reset in RESP suppresses the commit
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[word_idx] <= lane_merged;
    end
  end

  assign bus.req_ready = idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign stateout      = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder at LATENCY 2, 1 and 15.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned Depth = 256;

  logic       clock = 1'b0;
  logic       rst2;
  logic       rst_aux;
  logic [1:0] state2, state1, state15;
  int         checks = 0;
  int         failures = 0;

  logic [31:0] model_mem [Depth];

  always #5 clock = ~clock;

  mem_responder_if bus2 ();
  mem_responder_if bus1 ();
  mem_responder_if bus15 ();

  mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(2)) u_dut2 (
    .clock    (clock),
    .reset    (rst2),
    .bus      (bus2),
    .stateout (state2)
  );

  mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(1)) u_dut1 (
    .clock    (clock),
    .reset    (rst_aux),
    .bus      (bus1),
    .stateout (state1)
  );

  mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(15)) u_dut15 (
    .clock    (clock),
    .reset    (rst_aux),
    .bus      (bus15),
    .stateout (state15)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: byte-wise little-endian access over a word array
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int nbytes;
    int lane;
    logic [31:0] w;
    rd = '0;
    er = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0) ||
         (addr[31:2] >= Depth);
    if (er) return;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane   = int'(addr[1:0]);
    w      = model_mem[addr[9:2]];
    for (int i = 0; i < nbytes; i++) begin
      if (wr) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      else    rd[8*i +: 8] = w[8*(lane+i) +: 8];
    end
    if (wr) model_mem[addr[9:2]] = w;
  endtask

  // One transaction on the LATENCY=2 instance; lat = cycles from accept to rsp_valid, -1 on timeout
  task automatic req2(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n = 0;
    bus2.req_valid = 1'b1;
    bus2.req_write = wr;
    bus2.req_size  = sz;
    bus2.req_addr  = addr;
    bus2.req_wdata = wd;
    while (!bus2.req_ready && n < 20) begin
      step();
      n++;
    end
    step();
    bus2.req_valid = 1'b0;
    lat = 1;
    while (!bus2.rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!bus2.rsp_valid) lat = -1;
    rd = bus2.rsp_rdata;
    er = bus2.rsp_error;
    step();
  endtask

  task automatic test_reset();
    rst2    = 1'b1;
    rst_aux = 1'b1;
    // Request during reset must not be accepted
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    bus2.req_size  = SIZE_WORD;
    bus2.req_addr  = 32'h30;
    bus2.req_wdata = 32'h5555_5555;
    step();
    step();
    rst2           = 1'b0;
    rst_aux        = 1'b0;
    bus2.req_valid = 1'b0;
    checks++;
    if (state2 !== 2'd0) $display("FAIL reset_state2: got %0d expected 0", state2);
    if (state2 !== 2'd0) failures++;
    checks++;
    if (bus2.req_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", bus2.req_ready);
      failures++;
    end
    checks++;
    if (bus2.rsp_valid !== 1'b0 || bus2.rsp_error !== 1'b0 || bus2.rsp_rdata !== 32'h0) begin
      $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0/0/0",
               bus2.rsp_valid, bus2.rsp_error, bus2.rsp_rdata);
      failures++;
    end
    checks++;
    if (state1 !== 2'd0 || state15 !== 2'd0) begin
      $display("FAIL reset_aux_state: got %0d,%0d expected 0,0", state1, state15);
      failures++;
    end
  endtask

  task automatic test_word_basic();
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b1, SIZE_WORD, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    model_mem[4] = 32'hDEAD_BEEF;
    checks++;
    if (lat !== 2) begin
      $display("FAIL word_store_lat: got %0d expected 2", lat);
      failures++;
    end
    req2(1'b0, SIZE_WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (lat !== 2) begin
      $display("FAIL word_load_lat: got %0d expected 2", lat);
      failures++;
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      $display("FAIL word_load_data: got %h err=%b expected deadbeef err=0", rd, er);
      failures++;
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b1, SIZE_WORD, 32'h10, 32'h1122_3344, rd, er, lat);
    req2(1'b1, SIZE_BYTE, 32'h13, 32'h0000_00AA, rd, er, lat);
    model_mem[4] = 32'hAA22_3344;
    req2(1'b0, SIZE_WORD, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hAA22_3344 || er !== 1'b0) begin
      $display("FAIL byte_merge_word: got %h err=%b expected aa223344 err=0", rd, er);
      failures++;
    end
    req2(1'b0, SIZE_BYTE, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_00AA || er !== 1'b0) begin
      $display("FAIL byte_load: got %h err=%b expected 000000aa err=0", rd, er);
      failures++;
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b0, SIZE_HALF, 32'h11, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 2) begin
      $display("FAIL half_misalign: got %h err=%b lat=%0d expected 0 err=1 lat=2", rd, er, lat);
      failures++;
    end
    req2(1'b1, SIZE_WORD, 32'h0, 32'h55AA_55AA, rd, er, lat);
    model_mem[0] = 32'h55AA_55AA;
    req2(1'b1, SIZE_WORD, 4 * Depth, 32'hFFFF_FFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL range_store: got err=%b d=%h expected err=1 d=0", er, rd);
      failures++;
    end
    req2(1'b1, SIZE_WORD, 32'h2, 32'h0BAD_0BAD, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      $display("FAIL word_misalign: got err=%b expected 1", er);
      failures++;
    end
    req2(1'b0, 2'd3, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      $display("FAIL illegal_size: got err=%b d=%h expected err=1 d=0", er, rd);
      failures++;
    end
    req2(1'b0, SIZE_WORD, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h55AA_55AA || er !== 1'b0) begin
      $display("FAIL error_no_write: got %h err=%b expected 55aa55aa err=0", rd, er);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int lat;
    logic seen;
    req2(1'b1, SIZE_WORD, 32'h20, 32'h0, rd, er, lat);
    model_mem[8] = 32'h0;
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    bus2.req_size  = SIZE_WORD;
    bus2.req_addr  = 32'h20;
    bus2.req_wdata = 32'h1234_5678;
    step();
    bus2.req_valid = 1'b0;
    checks++;
    if (state2 !== 2'd1) begin
      $display("FAIL mid_wait_state: got %0d expected 1", state2);
      failures++;
    end
    rst2 = 1'b1;
    seen = bus2.rsp_valid;
    step();
    rst2 = 1'b0;
    checks++;
    if (state2 !== 2'd0) begin
      $display("FAIL mid_reset_state: got %0d expected 0", state2);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      seen = seen | bus2.rsp_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL mid_reset_rsp: got rsp_valid=%b expected 0", seen);
      failures++;
    end
    req2(1'b0, SIZE_WORD, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      $display("FAIL mid_reset_data: got %h err=%b lat=%0d expected 0 err=0 lat=2", rd, er, lat);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd;
    logic er, exp_er, wr;
    logic [1:0] sz;
    int lat, r, off;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      req2(1'b1, SIZE_WORD, 32'(w * 4), wd, rd, er, lat);
      model_access(1'b1, SIZE_WORD, 32'(w * 4), wd, exp_rd, exp_er);
    end
    for (int i = 0; i < 80; i++) begin
      r   = $urandom_range(0, 9);
      wr  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 2));
      off = $urandom_range(0, 3);
      if (r < 6) off = (sz == SIZE_BYTE) ? off : (sz == SIZE_HALF) ? (off & 2) : 0;
      if (r == 8) sz = 2'd3;
      addr = 32'($urandom_range(0, 15) * 4 + off);
      if (r == 9) addr = 32'($urandom_range(Depth, 100000) * 4 + off);
      wd = $urandom;
      req2(wr, sz, addr, wd, rd, er, lat);
      model_access(wr, sz, addr, wd, exp_rd, exp_er);
      checks++;
      if (lat !== 2) begin
        $display("FAIL rand_lat[%0d]: got %0d expected 2", i, lat);
        failures++;
      end
      checks++;
      if (er !== exp_er) begin
        $display("FAIL rand_err[%0d] wr=%b sz=%0d a=%h: got %b expected %b",
                 i, wr, sz, addr, er, exp_er);
        failures++;
      end
      checks++;
      if (rd !== exp_rd) begin
        $display("FAIL rand_data[%0d] wr=%b sz=%0d a=%h: got %h expected %h",
                 i, wr, sz, addr, rd, exp_rd);
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_size  = SIZE_WORD;
    bus1.req_addr  = 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus1.req_wdata = 32'h1000_0000 + 32'(i);
      checks++;
      if (bus1.req_ready !== (i % 2 == 0)) begin
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, bus1.req_ready, (i % 2 == 0));
        failures++;
      end
      checks++;
      if (bus1.rsp_valid !== (i % 2 == 1)) begin
        $display("FAIL b2b_rsp[%0d]: got %b expected %b", i, bus1.rsp_valid, (i % 2 == 1));
        failures++;
      end
      step();
    end
    bus1.req_write = 1'b0;
    checks++;
    if (bus1.req_ready !== 1'b1) begin
      $display("FAIL b2b_load_ready: got %b expected 1", bus1.req_ready);
      failures++;
    end
    step();
    bus1.req_valid = 1'b0;
    checks++;
    if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rdata !== 32'h1000_0006 || bus1.rsp_error !== 1'b0) begin
      $display("FAIL b2b_load: got v=%b d=%h e=%b expected 1/10000006/0",
               bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_error);
      failures++;
    end
    step();
    checks++;
    if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1 || bus1.rsp_rdata !== 32'h0) begin
      $display("FAIL b2b_tail: got v=%b r=%b d=%h expected 0/1/0",
               bus1.rsp_valid, bus1.req_ready, bus1.rsp_rdata);
      failures++;
    end
  endtask

  task automatic test_latency15();
    int lat;
    bus15.req_valid = 1'b1;
    bus15.req_write = 1'b1;
    bus15.req_size  = SIZE_WORD;
    bus15.req_addr  = 32'h8;
    bus15.req_wdata = 32'h0BAD_F00D;
    checks++;
    if (bus15.req_ready !== 1'b1) begin
      $display("FAIL lat15_idle_ready: got %b expected 1", bus15.req_ready);
      failures++;
    end
    step();
    bus15.req_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      checks++;
      if (bus15.req_ready !== 1'b0) begin
        $display("FAIL lat15_ready[%0d]: got %b expected 0", k, bus15.req_ready);
        failures++;
      end
      checks++;
      if (bus15.rsp_valid !== (k == 15)) begin
        $display("FAIL lat15_rsp[%0d]: got %b expected %b", k, bus15.rsp_valid, (k == 15));
        failures++;
      end
      step();
    end
    checks++;
    if (bus15.req_ready !== 1'b1 || bus15.rsp_valid !== 1'b0) begin
      $display("FAIL lat15_after: got r=%b v=%b expected 1/0", bus15.req_ready, bus15.rsp_valid);
      failures++;
    end
    bus15.req_valid = 1'b1;
    bus15.req_write = 1'b0;
    step();
    bus15.req_valid = 1'b0;
    lat = 1;
    while (!bus15.rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 15 || bus15.rsp_rdata !== 32'h0BAD_F00D) begin
      $display("FAIL lat15_load: got lat=%0d d=%h expected 15/0badf00d", lat, bus15.rsp_rdata);
      failures++;
    end
    step();
  endtask

  initial begin
    rst2 = 1'b1;
    rst_aux = 1'b1;
    bus2.req_valid  = 1'b0;
    bus2.req_write  = 1'b0;
    bus2.req_size   = '0;
    bus2.req_addr   = '0;
    bus2.req_wdata  = '0;
    bus1.req_valid  = 1'b0;
    bus1.req_write  = 1'b0;
    bus1.req_size   = '0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;
    bus15.req_valid = 1'b0;
    bus15.req_write = 1'b0;
    bus15.req_size  = '0;
    bus15.req_addr  = '0;
    bus15.req_wdata = '0;
    for (int i = 0; i < int'(Depth); i++) model_mem[i] = '0;
    test_reset();
    test_word_basic();
    test_byte_merge();
    test_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_latency15();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle processor's memory port: accepts one load/store request at a time from the control unit/datapath, holds it for a fixed latency, then commits the write or returns read data with a one-cycle response pulse. It sits between the datapath's address mux (Iord) / MemWr path and the instruction/data register inputs. It replaces the fixed wait states in the control sequencer with an explicit request/response handshake.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the internal array; word index = req_addr[31:2].
- LATENCY, 2: cycles from accept to response; legal range 1..15.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, zero-extended, right-justified; 0 for stores and errors.
- rsp_error  out  1  qualified by rsp_valid; misaligned, out-of-range or illegal size.
- stateout  out  2  current FSM state, for debug/waveforms.

## Operation
- States: IDLE (0), WAIT (1), RESP (2).
- IDLE: req_ready = 1. On accept, register write/size/addr/wdata; next = WAIT with count = LATENCY-1, or RESP directly if LATENCY = 1.
- WAIT: req_ready = 0; count decrements each cycle; at count = 0 next = RESP. Inputs ignored.
- RESP: rsp_valid = 1 for exactly this cycle; store committed to the array on the edge ending RESP; next = IDLE. No back-pressure on the response.
- Byte lanes little-endian: lane = addr[1:0] (byte) or addr[1]*2 (half). Store merges only the addressed lanes; other bytes unchanged. Load extracts the lane, zero-extends to 32 bits.
- Error if size = 3, half with addr[0] = 1, word with addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS: no array write, rsp_rdata = 0, rsp_error = 1.
- Array contents are not cleared by reset.

## Timing
- Accept on edge ending cycle T; rsp_valid high in cycle T+LATENCY; next accept possible in cycle T+LATENCY+1. Throughput: one request per LATENCY+1 cycles.
- rsp_rdata/rsp_error registered; valid only while rsp_valid = 1, held at 0 otherwise.
- Reset values: state IDLE, count 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, stateout 0; req_ready = 1 from the first cycle after reset.
- Reset mid-operation (WAIT or RESP): pending request dropped, no store committed, no rsp_valid.
- Request presented in the same cycle reset is high is not accepted.
- Load after store to the same word: store commits at end of its RESP cycle; the following load observes the new data.

## Structure
- Package mem_pkg: state enum (IDLE/WAIT/RESP, 2 bits), size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD, LATENCY width constant.
- Sub-module mem_lane_unit (combinational): given size, addr[1:0], old word and wdata, produces the merged store word, the extracted load data and the misalignment flag. The top holds the FSM, counter, request registers and array.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x10 and word load at 0x10 (LATENCY=2) -> rsp_valid in cycle T+2 after each accept, load rdata = 0xDEADBEEF, rsp_error = 0.
- Byte store 0xAA at 0x13 onto word 0x11223344 at 0x10 -> word load returns 0xAA223344; byte load at 0x13 returns 0x000000AA.
- Half load at 0x11 -> rsp_error = 1, rsp_rdata = 0; word store to address 4*DEPTH_WORDS -> rsp_error = 1 and array unchanged.
- req_valid held high continuously with LATENCY=1 -> req_ready pattern 1,0,1,0; one rsp_valid pulse every 2 cycles.
- Reset asserted in WAIT of a store to 0x20 holding 0x0 -> no rsp_valid; later load at 0x20 returns 0x0; stateout = 0 after reset.
- LATENCY=15 -> rsp_valid exactly 15 cycles after accept; req_ready low for the 15 intervening cycles.
